// File: rtl/tweezer_param_scheduler.sv
// Purpose: applies host-written PI coefficients, setpoint and limits on sample boundaries, ramping setpoint and freezing integrator on ki change.
// Latency: a command applies on the first sample_valid after acceptance (or TIMEOUT cycles later); outputs are visible the cycle after that edge.
// Backpressure: cmd_ready is high only in IDLE; a command is held off until the previous one (including ramp/hold) has finished.
module tweezer_param_scheduler #(
    parameter int          DATA_W         = 16,
    parameter int          COEFF_W        = 10,
    parameter int unsigned RAMP_STEP      = 16'd64,
    parameter int unsigned FREEZE_SAMPLES = 4,
    parameter int unsigned TIMEOUT        = 1024
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [2:0]         cmd_addr,
    input  logic [DATA_W-1:0]  cmd_data,
    input  logic               sample_valid,
    output logic [COEFF_W-1:0] PI_kp,
    output logic [COEFF_W-1:0] PI_ki,
    output logic               PI_kp_update,
    output logic               PI_ki_update,
    output logic [DATA_W-1:0]  PI_setpoint,
    output logic [DATA_W-1:0]  pi_limit_LO,
    output logic [DATA_W-1:0]  pi_limit_HI,
    output logic               PI_freeze,
    output logic               busy,
    output logic               cmd_err
);

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        WAIT_SAMPLE = 3'd1,
        APPLY       = 3'd2,
        RAMP        = 3'd3,
        HOLD        = 3'd4
    } state_t;

    localparam int WC_W = $clog2(TIMEOUT) + 1;
    localparam int HC_W = $clog2(FREEZE_SAMPLES) + 1;
    localparam logic [WC_W-1:0] WC_LAST = WC_W'(TIMEOUT - 1);
    localparam logic [HC_W-1:0] HC_LAST = HC_W'(FREEZE_SAMPLES - 1);
    // Step widened by one bit so setpoint +/- step never wraps at the signed extremes.
    localparam logic signed [DATA_W:0] STEP_X = $signed((DATA_W+1)'(RAMP_STEP));

    state_t              state, state_nx;
    logic [2:0]          addr_q;
    logic [DATA_W-1:0]   data_q;
    logic [WC_W-1:0]     wcnt;
    logic [HC_W-1:0]     hcnt;

    logic                accept;
    logic                addr_ok;
    logic                wait_done;
    logic                hold_done;
    logic                sp_eq;
    logic                lo_bad;
    logic                hi_bad;
    logic signed [DATA_W:0] tgt_x, sp_x, diff;
    logic [DATA_W-1:0]   sp_next;

    assign accept    = (state == IDLE) && cmd_valid;
    assign addr_ok   = (cmd_addr <= 3'd4);
    assign wait_done = (state == WAIT_SAMPLE) && (sample_valid || (wcnt == WC_LAST));
    assign hold_done = (state == HOLD) && sample_valid && (hcnt == HC_LAST);
    assign sp_eq     = (PI_setpoint == data_q);
    assign lo_bad    = $signed(data_q) > $signed(pi_limit_HI);
    assign hi_bad    = $signed(pi_limit_LO) > $signed(data_q);

    assign tgt_x = $signed({data_q[DATA_W-1], data_q});
    assign sp_x  = $signed({PI_setpoint[DATA_W-1], PI_setpoint});
    assign diff  = tgt_x - sp_x;

    // Next ramp value: move at most one step toward the target, landing exactly on it.
    always_comb begin
        sp_next = data_q;
        if (diff > STEP_X) begin
            sp_next = DATA_W'(sp_x + STEP_X);
        end else if (diff < -STEP_X) begin
            sp_next = DATA_W'(sp_x - STEP_X);
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic; the state being left is the only one that consumes a sample strobe.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:        if (accept && addr_ok) state_nx = WAIT_SAMPLE;
            WAIT_SAMPLE: if (wait_done) state_nx = APPLY;
            APPLY: begin
                case (addr_q)
                    3'd1:    state_nx = HOLD;
                    3'd2:    state_nx = RAMP;
                    default: state_nx = IDLE;
                endcase
            end
            RAMP:        if (sp_eq) state_nx = IDLE;
            HOLD:        if (hold_done) state_nx = IDLE;
            default:     state_nx = IDLE;
        endcase
    end

    // Registered datapath: command latch, counters, applied values and pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cmd_ready    <= 1'b1;
            busy         <= 1'b0;
            cmd_err      <= 1'b0;
            addr_q       <= '0;
            data_q       <= '0;
            wcnt         <= '0;
            hcnt         <= '0;
            PI_kp        <= '0;
            PI_ki        <= '0;
            PI_kp_update <= 1'b0;
            PI_ki_update <= 1'b0;
            PI_setpoint  <= '0;
            pi_limit_LO  <= {1'b1, {(DATA_W-1){1'b0}}};
            pi_limit_HI  <= {1'b0, {(DATA_W-1){1'b1}}};
            PI_freeze    <= 1'b0;
        end else begin
            PI_kp_update <= 1'b0;
            PI_ki_update <= 1'b0;
            cmd_err      <= 1'b0;
            cmd_ready    <= (state_nx == IDLE);
            busy         <= (state_nx != IDLE);

            if (accept) begin
                addr_q <= cmd_addr;
                data_q <= cmd_data;
                if (!addr_ok) cmd_err <= 1'b1;
            end

            if ((state == WAIT_SAMPLE) && !wait_done) begin
                wcnt <= wcnt + WC_W'(1);
            end else begin
                wcnt <= '0;
            end

            // Values become visible during the APPLY cycle.
            if (wait_done) begin
                case (addr_q)
                    3'd0: begin
                        PI_kp        <= data_q[COEFF_W-1:0];
                        PI_kp_update <= 1'b1;
                    end
                    3'd1: begin
                        PI_ki        <= data_q[COEFF_W-1:0];
                        PI_ki_update <= 1'b1;
                        PI_freeze    <= 1'b1;
                    end
                    3'd3: begin
                        if (lo_bad) cmd_err <= 1'b1;
                        else        pi_limit_LO <= data_q;
                    end
                    3'd4: begin
                        if (hi_bad) cmd_err <= 1'b1;
                        else        pi_limit_HI <= data_q;
                    end
                    default: ;
                endcase
            end

            if ((state == RAMP) && sample_valid && !sp_eq) begin
                PI_setpoint <= sp_next;
            end

            if ((state == HOLD) && sample_valid) begin
                if (hold_done) begin
                    hcnt      <= '0;
                    PI_freeze <= 1'b0;
                end else begin
                    hcnt <= hcnt + HC_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_tweezer_param_scheduler.sv
// Purpose: directed self-checking bench for tweezer_param_scheduler.
// Latency: checks are taken 1ns after each rising edge.
// Backpressure: commands are only issued while the scheduler is idle.
module tb_tweezer_param_scheduler;

    logic        clk;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_addr;
    logic [15:0] cmd_data;
    logic        sample_valid;
    logic [9:0]  PI_kp, PI_ki;
    logic        PI_kp_update, PI_ki_update;
    logic [15:0] PI_setpoint, pi_limit_LO, pi_limit_HI;
    logic        PI_freeze, busy, cmd_err;

    int total = 0;
    int bad   = 0;

    tweezer_param_scheduler dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .sample_valid(sample_valid),
        .PI_kp(PI_kp), .PI_ki(PI_ki), .PI_kp_update(PI_kp_update), .PI_ki_update(PI_ki_update),
        .PI_setpoint(PI_setpoint), .pi_limit_LO(pi_limit_LO), .pi_limit_HI(pi_limit_HI),
        .PI_freeze(PI_freeze), .busy(busy), .cmd_err(cmd_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one command for exactly one (accepting) edge.
    task automatic send_cmd(input logic [2:0] a, input logic [15:0] d);
        cmd_valid = 1'b1;
        cmd_addr  = a;
        cmd_data  = d;
        tick();
        cmd_valid = 1'b0;
    endtask

    // Command followed by an immediate sample strobe; returns in the APPLY cycle.
    task automatic send_apply(input logic [2:0] a, input logic [15:0] d);
        send_cmd(a, d);
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) tick();
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL rst_cmd_ready got=%b exp=1", cmd_ready); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
        total++; if (PI_kp !== 10'h000 || PI_ki !== 10'h000) begin bad++; $display("FAIL rst_coeff got=%h/%h exp=000/000", PI_kp, PI_ki); end
        total++; if (PI_setpoint !== 16'h0000) begin bad++; $display("FAIL rst_setpoint got=%h exp=0000", PI_setpoint); end
        total++; if (pi_limit_LO !== 16'h8000 || pi_limit_HI !== 16'h7FFF) begin bad++; $display("FAIL rst_limits got=%h/%h exp=8000/7fff", pi_limit_LO, pi_limit_HI); end
        total++; if ({PI_freeze, PI_kp_update, PI_ki_update, cmd_err} !== 4'b0000) begin bad++; $display("FAIL rst_flags got=%b exp=0000", {PI_freeze, PI_kp_update, PI_ki_update, cmd_err}); end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_kp();
        send_cmd(3'd0, 16'h0123);
        total++; if (cmd_ready !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL kp_wait_hs got=%b%b exp=01", cmd_ready, busy); end
        repeat (4) tick();
        total++; if (PI_kp !== 10'h000) begin bad++; $display("FAIL kp_early got=%h exp=000", PI_kp); end
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        total++; if (PI_kp !== 10'h123) begin bad++; $display("FAIL kp_apply got=%h exp=123", PI_kp); end
        total++; if (PI_kp_update !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL kp_pulse got=%b%b exp=11", PI_kp_update, busy); end
        tick();
        total++; if (PI_kp_update !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin bad++; $display("FAIL kp_done got=%b%b%b exp=001", PI_kp_update, busy, cmd_ready); end
    endtask

    task automatic test_ki_freeze();
        send_cmd(3'd1, 16'h0040);
        sample_valid = 1'b1;
        tick();
        // Strobe stays high through APPLY: it must not count toward the hold.
        total++; if (PI_ki !== 10'h040 || PI_ki_update !== 1'b1 || PI_freeze !== 1'b1) begin bad++; $display("FAIL ki_apply got=%h %b %b exp=040 1 1", PI_ki, PI_ki_update, PI_freeze); end
        tick();
        sample_valid = 1'b0;
        total++; if (PI_ki_update !== 1'b0 || PI_freeze !== 1'b1) begin bad++; $display("FAIL ki_hold_entry got=%b%b exp=01", PI_ki_update, PI_freeze); end
        for (int i = 0; i < 4; i++) begin
            sample_valid = 1'b1;
            tick();
            sample_valid = 1'b0;
            total++; if (PI_freeze !== (i < 3)) begin bad++; $display("FAIL ki_freeze_%0d got=%b exp=%b", i, PI_freeze, (i < 3)); end
            tick();
        end
        total++; if (busy !== 1'b0 || cmd_ready !== 1'b1) begin bad++; $display("FAIL ki_idle got=%b%b exp=01", busy, cmd_ready); end
    endtask

    task automatic test_ramp(input logic [15:0] tgt, input int n,
                             input logic [15:0] e0, input logic [15:0] e1,
                             input logic [15:0] e2, input logic [15:0] e3);
        logic [15:0] exp_sp [4];
        logic [15:0] start;
        exp_sp = '{e0, e1, e2, e3};
        start  = PI_setpoint;
        send_cmd(3'd2, tgt);
        sample_valid = 1'b1;
        tick();
        tick();
        sample_valid = 1'b0;
        total++; if (PI_setpoint !== start) begin bad++; $display("FAIL ramp_apply_strobe got=%h exp=%h", PI_setpoint, start); end
        for (int i = 0; i < n; i++) begin
            sample_valid = 1'b1;
            tick();
            sample_valid = 1'b0;
            total++; if (PI_setpoint !== exp_sp[i] || busy !== 1'b1) begin bad++; $display("FAIL ramp_step_%0d got=%h busy=%b exp=%h busy=1", i, PI_setpoint, busy, exp_sp[i]); end
            tick();
        end
        total++; if (busy !== 1'b0 || cmd_ready !== 1'b1) begin bad++; $display("FAIL ramp_done got=%b%b exp=01", busy, cmd_ready); end
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        total++; if (PI_setpoint !== tgt) begin bad++; $display("FAIL ramp_overshoot got=%h exp=%h", PI_setpoint, tgt); end
    endtask

    task automatic test_limits();
        send_apply(3'd4, 16'h0800);
        total++; if (pi_limit_HI !== 16'h0800 || cmd_err !== 1'b0) begin bad++; $display("FAIL hi_set got=%h err=%b exp=0800 err=0", pi_limit_HI, cmd_err); end
        tick();
        send_apply(3'd3, 16'h1000);
        total++; if (cmd_err !== 1'b1 || pi_limit_LO !== 16'h8000) begin bad++; $display("FAIL lo_reject got=err%b %h exp=err1 8000", cmd_err, pi_limit_LO); end
        tick();
        total++; if (cmd_err !== 1'b0) begin bad++; $display("FAIL lo_reject_pulse got=%b exp=0", cmd_err); end
        send_apply(3'd3, 16'h0800);
        total++; if (pi_limit_LO !== 16'h0800 || cmd_err !== 1'b0) begin bad++; $display("FAIL lo_equal got=%h err=%b exp=0800 err=0", pi_limit_LO, cmd_err); end
        tick();
        send_apply(3'd4, 16'h0700);
        total++; if (cmd_err !== 1'b1 || pi_limit_HI !== 16'h0800) begin bad++; $display("FAIL hi_reject got=err%b %h exp=err1 0800", cmd_err, pi_limit_HI); end
        tick();
        send_cmd(3'd6, 16'h0FFF);
        total++; if (cmd_err !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL addr6_err got=%b busy=%b exp=1 busy=0", cmd_err, busy); end
        tick();
        total++; if (cmd_err !== 1'b0 || PI_kp !== 10'h123 || PI_ki !== 10'h040 || pi_limit_LO !== 16'h0800 || pi_limit_HI !== 16'h0800) begin bad++; $display("FAIL addr6_nochange got=err%b %h %h %h %h", cmd_err, PI_kp, PI_ki, pi_limit_LO, pi_limit_HI); end
    endtask

    task automatic test_timeout();
        int cnt;
        sample_valid = 1'b0;
        send_cmd(3'd0, 16'h0055);
        cnt = 1;
        while (PI_kp_update !== 1'b1 && cnt < 2000) begin
            tick();
            if (PI_kp_update !== 1'b1) cnt++;
        end
        total++; if (cnt !== 1024) begin bad++; $display("FAIL timeout_cycles got=%0d exp=1024", cnt); end
        total++; if (PI_kp !== 10'h055) begin bad++; $display("FAIL timeout_kp got=%h exp=055", PI_kp); end
        tick();
    endtask

    task automatic test_reset_mid_ramp();
        send_cmd(3'd2, 16'h0100);
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        tick();
        for (int i = 0; i < 2; i++) begin
            sample_valid = 1'b1;
            tick();
            sample_valid = 1'b0;
        end
        total++; if (PI_setpoint !== 16'h0040 || busy !== 1'b1) begin bad++; $display("FAIL mid_ramp_pre got=%h busy=%b exp=0040 busy=1", PI_setpoint, busy); end
        reset = 1'b0;
        #2;
        total++; if (PI_setpoint !== 16'h0000 || busy !== 1'b0 || cmd_ready !== 1'b1) begin bad++; $display("FAIL mid_ramp_async got=%h busy=%b rdy=%b exp=0000 0 1", PI_setpoint, busy, cmd_ready); end
        total++; if (PI_kp !== 10'h000 || pi_limit_LO !== 16'h8000 || pi_limit_HI !== 16'h7FFF || PI_freeze !== 1'b0) begin bad++; $display("FAIL mid_ramp_outputs got=%h %h %h %b", PI_kp, pi_limit_LO, pi_limit_HI, PI_freeze); end
        reset = 1'b1;
        tick();
        total++; if (cmd_ready !== 1'b1 || busy !== 1'b0 || PI_setpoint !== 16'h0000) begin bad++; $display("FAIL post_reset got=rdy%b busy%b %h exp=rdy1 busy0 0000", cmd_ready, busy, PI_setpoint); end
        send_apply(3'd0, 16'h00AA);
        total++; if (PI_kp !== 10'h0AA || PI_kp_update !== 1'b1) begin bad++; $display("FAIL post_reset_kp got=%h %b exp=0aa 1", PI_kp, PI_kp_update); end
        tick();
    endtask

    initial begin
        reset        = 1'b0;
        cmd_valid    = 1'b0;
        cmd_addr     = 3'd0;
        cmd_data     = 16'h0000;
        sample_valid = 1'b0;
        test_reset();
        test_kp();
        test_ki_freeze();
        test_ramp(16'h00A0, 3, 16'h0040, 16'h0080, 16'h00A0, 16'h0000);
        test_ramp(16'hFFC0, 4, 16'h0060, 16'h0020, 16'hFFE0, 16'hFFC0);
        test_limits();
        test_timeout();
        test_reset_mid_ramp();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
